// File: rtl/legv8_multicycle_control.sv
// legv8_multicycle_control: multicycle FSM that latches, decodes and sequences LEGv8 instructions
`timescale 1ns/1ps
module legv8_multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [4:0]  status,
  output logic [29:0] control_word,
  output logic [63:0] constant,
  output logic        halted,
  output logic [1:0]  state
);
  localparam logic [1:0] FETCH = 2'b00, EXEC = 2'b01, MEM = 2'b10, HALT = 2'b11;
  localparam logic [4:0] FS_ADD = 5'b01000, FS_SUB = 5'b01001, FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100, FS_EOR = 5'b01100, FS_PASSB = 5'b11000;
  logic [1:0] state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [10:0] op;
  logic [4:0] rn, rm, rd;
  logic is_add, is_sub, is_and, is_orr, is_eor, is_adds, is_subs, is_addi, is_subi;
  logic is_stur, is_ldur, is_cbz, is_cbnz, is_b, is_bl, is_br, is_bcond;
  logic is_rtype, known, cb_taken, cond_base, cond_taken;
  logic v, c, n, z;
  logic en_pc, en_mem, en_alu, pc_sel, b_sel, sl, wm, wr;
  logic [1:0] ps;
  logic [4:0] fs, sb, sa, da;
  logic [63:0] imm_alu, imm_dt, imm_cb, imm_b;
  assign op = ir_q[31:21];
  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];
  assign rd = ir_q[4:0];
  assign {v, c, n, z} = status[4:1];
  assign is_add = op == 11'b10001011000;
  assign is_sub = op == 11'b11001011000;
  assign is_and = op == 11'b10001010000;
  assign is_orr = op == 11'b10101010000;
  assign is_eor = op == 11'b11001010000;
  assign is_adds = op == 11'b10101011000;
  assign is_subs = op == 11'b11101011000;
  assign is_addi = op[10:1] == 10'b1001000100;
  assign is_subi = op[10:1] == 10'b1101000100;
  assign is_stur = op == 11'b11111000000;
  assign is_ldur = op == 11'b11111000010;
  assign is_cbz = op[10:3] == 8'b10110100;
  assign is_cbnz = op[10:3] == 8'b10110101;
  assign is_b = op[10:5] == 6'b000101;
  assign is_bl = op[10:5] == 6'b100101;
  assign is_br = op == 11'b11010110000;
  assign is_bcond = op[10:3] == 8'b01010100;
  assign is_rtype = is_add | is_sub | is_and | is_orr | is_eor | is_adds | is_subs;
  assign known = is_rtype | is_addi | is_subi | is_stur | is_ldur | is_cbz | is_cbnz | is_b | is_bl | is_br | is_bcond;
  assign imm_alu = {52'b0, ir_q[21:10]};
  assign imm_dt = {{55{ir_q[20]}}, ir_q[20:12]};
  assign imm_cb = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
  assign imm_b = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
  assign cb_taken = is_cbz ? status[0] : ~status[0];
  assign cond_base = ir_q[3:1] == 3'd0 ? z :
                     ir_q[3:1] == 3'd1 ? c :
                     ir_q[3:1] == 3'd2 ? n :
                     ir_q[3:1] == 3'd3 ? v :
                     ir_q[3:1] == 3'd4 ? c & ~z :
                     ir_q[3:1] == 3'd5 ? n ~^ v :
                     ir_q[3:1] == 3'd6 ? ~z & (n ~^ v) : 1'b1;
  assign cond_taken = (ir_q[3:1] == 3'b111) | (cond_base ^ ir_q[0]);
  // State and instruction register; reset returns to FETCH with an empty IR
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  // Sequencing: IR loads only in FETCH, LDUR adds a MEM cycle, unknown opcodes park in HALT
  always_comb begin
    ir_d = state_q == FETCH ? instruction : ir_q;
    state_d = state_q == FETCH ? EXEC :
              state_q == EXEC ? (!known ? HALT : is_ldur ? MEM : FETCH) :
              state_q == MEM ? FETCH : HALT;
  end
  // Datapath control word and constant; only EXEC and MEM drive anything
  always_comb begin
    en_pc = 1'b0;
    en_mem = 1'b0;
    en_alu = 1'b0;
    pc_sel = 1'b0;
    b_sel = 1'b0;
    sl = 1'b0;
    wm = 1'b0;
    wr = 1'b0;
    ps = 2'b00;
    fs = 5'b0;
    sb = 5'b0;
    sa = 5'b0;
    da = 5'b0;
    constant = '0;
    if (state_q == EXEC) begin
      if (is_rtype) begin
        sa = rn;
        sb = rm;
        da = rd;
        en_alu = 1'b1;
        wr = 1'b1;
        ps = 2'b01;
        sl = is_adds | is_subs;
        fs = is_add | is_adds ? FS_ADD : is_sub | is_subs ? FS_SUB : is_and ? FS_AND : is_orr ? FS_ORR : FS_EOR;
      end
      if (is_addi | is_subi) begin
        b_sel = 1'b1;
        constant = imm_alu;
        sa = rn;
        da = rd;
        en_alu = 1'b1;
        wr = 1'b1;
        ps = 2'b01;
        fs = is_addi ? FS_ADD : FS_SUB;
      end
      if (is_stur) begin
        sa = rn;
        sb = rd;
        b_sel = 1'b1;
        fs = FS_ADD;
        constant = imm_dt;
        wm = 1'b1;
        ps = 2'b01;
      end
      if (is_ldur) begin
        sa = rn;
        b_sel = 1'b1;
        fs = FS_ADD;
        constant = imm_dt;
        da = rd;
      end
      if (is_cbz | is_cbnz) begin
        sb = rd;
        fs = FS_PASSB;
        pc_sel = 1'b1;
        constant = imm_cb;
        ps = cb_taken ? 2'b10 : 2'b01;
      end
      if (is_b | is_bl) begin
        pc_sel = 1'b1;
        constant = imm_b;
        ps = 2'b10;
        en_pc = is_bl;
        wr = is_bl;
        da = is_bl ? 5'd30 : 5'd0;
      end
      if (is_br) begin
        sa = rn;
        ps = 2'b11;
      end
      if (is_bcond) begin
        pc_sel = 1'b1;
        constant = imm_cb;
        ps = cond_taken ? 2'b10 : 2'b01;
      end
    end else if (state_q == MEM) begin
      sa = rn;
      b_sel = 1'b1;
      fs = FS_ADD;
      constant = imm_dt;
      en_mem = 1'b1;
      wr = 1'b1;
      da = rd;
      ps = 2'b01;
    end
  end
  assign control_word = {en_pc, en_mem, en_alu, pc_sel, b_sel, sl, wm, wr, ps, fs, sb, sa, da};
  assign halted = state_q == HALT;
  assign state = state_q;
endmodule
